// File: rtl/seg7_pkg.sv
// Shared constants and scan-state encoding for the 3-digit 7-segment scan driver.
// Optional leading-zero blanking is enabled with the SEG7_LEADING_ZERO_BLANK_EN macro.
package seg7_pkg;

  localparam int DIGITS = 3;
  localparam int IDX_W  = 2;

  // Pattern {a..g} of the digit "0".
  localparam logic [6:0] SEG_ZERO = 7'b1111110;

  typedef enum logic {
    ST_ON  = 1'b0,
    ST_GAP = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_frame_buffer.sv
// Pending/display double buffer with the in_valid/in_ready capture handshake.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits at transfer time.
module seg7_frame_buffer
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       seg_h,
  input  logic [6:0]       seg_t,
  input  logic [6:0]       seg_o,
  input  logic             load,
  input  logic [IDX_W-1:0] idx,
  output logic [6:0]       cur_seg,
  output logic             cur_show
);

  // Handshake: a frame moves when in_valid && in_ready at a rising clk edge.
  // in_ready is a flop (== !pend_full) and never looks at in_valid.
  logic [6:0] pend_h, pend_t, pend_o;
  logic [6:0] disp_h, disp_t, disp_o;
  logic       pend_full;
  logic       disp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_h     <= '0;
      pend_t     <= '0;
      pend_o     <= '0;
      disp_h     <= '0;
      disp_t     <= '0;
      disp_o     <= '0;
      pend_full  <= 1'b0;
      in_ready   <= 1'b1;
      disp_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        pend_h    <= seg_h;
        pend_t    <= seg_t;
        pend_o    <= seg_o;
        pend_full <= 1'b1;
        in_ready  <= 1'b0;
      end
      // Capture needs in_ready, so it can never coincide with a transfer.
      if (load && pend_full) begin
        disp_h     <= pend_h;
        disp_t     <= pend_t;
        disp_o     <= pend_o;
        disp_valid <= 1'b1;
        pend_full  <= 1'b0;
        in_ready   <= 1'b1;
      end
    end
  end

  always_comb begin
    cur_seg = disp_o;
    case (idx)
      2'd0:    cur_seg = disp_h;
      2'd1:    cur_seg = disp_t;
      default: cur_seg = disp_o;
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic blank_h, blank_t;
  logic lz_h, lz_t;

  always_comb begin
    lz_h = (pend_h == SEG_ZERO);
    lz_t = lz_h && (pend_t == SEG_ZERO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_h <= 1'b0;
      blank_t <= 1'b0;
    end else if (load && pend_full) begin
      blank_h <= lz_h;
      blank_t <= lz_t;
    end
  end

  always_comb begin
    cur_show = disp_valid;
    case (idx)
      2'd0:    cur_show = disp_valid && !blank_h;
      2'd1:    cur_show = disp_valid && !blank_t;
      default: cur_show = disp_valid;
    endcase
  end
`else
  assign cur_show = disp_valid;
`endif

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes three 7-segment patterns onto one bus with blanking gaps.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (see seg7_frame_buffer).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE       = 1000,
  parameter int GAP_CYCLES     = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] seg_h,
  input  logic [6:0] seg_t,
  input  logic [6:0] seg_o,
  output logic [6:0] seg_out,
  output logic [2:0] dig_out,
  output logic       frame_done
);

  localparam int CNT_MAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // XOR masks: all-ones inverts the bus and doubles as the inactive level.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [2:0] DIG_OFF = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;

  scan_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [CNT_W-1:0] cnt;
  logic             advance;
  logic             boundary;
  logic [6:0]       cur_seg;
  logic             cur_show;

  always_comb begin
    advance  = 1'b0;
    if (state == ST_ON) advance = (cnt == ON_LAST) && (GAP_CYCLES == 0);
    else                advance = (cnt == GAP_LAST);
    boundary = advance && (idx == IDX_W'(DIGITS - 1));
    next_idx = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  seg7_frame_buffer u_frame_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .seg_h    (seg_h),
    .seg_t    (seg_t),
    .seg_o    (seg_o),
    .load     (boundary),
    .idx      (idx),
    .cur_seg  (cur_seg),
    .cur_show (cur_show)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ON;
      idx        <= '0;
      cnt        <= '0;
      seg_out    <= SEG_OFF;
      dig_out    <= DIG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;

      // Outputs reflect this cycle's scan position, visible one cycle later.
      if (state == ST_ON && cur_show) begin
        seg_out <= cur_seg ^ SEG_OFF;
        dig_out <= (3'b100 >> idx) ^ DIG_OFF;
      end else begin
        seg_out <= SEG_OFF;
        dig_out <= DIG_OFF;
      end

      case (state)
        ST_ON: begin
          if (cnt == ON_LAST) begin
            cnt <= '0;
            if (GAP_CYCLES == 0) idx   <= next_idx;
            else                 state <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= ST_ON;
            idx   <= next_idx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-cycle output model fed by a frame scoreboard.
// Build with SEG7_LEADING_ZERO_BLANK_EN defined to check leading-zero blanking.
module tb_seg7_scan_driver;

  localparam int PRE   = 4;
  localparam int GAP   = 2;
  localparam int FRAME = 3 * (PRE + GAP);
  localparam int FRAME0 = 3 * PRE;
  localparam logic [6:0] ZERO = 7'b1111110;
  localparam logic [9:0] ALL_OFF = {3'b111, 7'b0000000};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, frame_done;
  logic [6:0] seg_h, seg_t, seg_o, seg_out;
  logic [2:0] dig_out;

  // Second instance without gaps, fed one constant frame (8, 7, 9).
  logic       in_valid0;
  logic       in_ready0, frame_done0;
  logic [6:0] seg_out0;
  logic [2:0] dig_out0;
  logic [20:0] f0;

  seg7_scan_driver #(
    .PRESCALE(PRE), .GAP_CYCLES(GAP), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .seg_h(seg_h), .seg_t(seg_t), .seg_o(seg_o),
    .seg_out(seg_out), .dig_out(dig_out), .frame_done(frame_done)
  );

  seg7_scan_driver #(
    .PRESCALE(PRE), .GAP_CYCLES(0), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut_nogap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .seg_h(f0[20:14]), .seg_t(f0[13:7]), .seg_o(f0[6:0]),
    .seg_out(seg_out0), .dig_out(dig_out0), .frame_done(frame_done0)
  );

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [20:0] exp_q[$];
  int          acc_q[$];
  logic [20:0] shown;
  logic        shown_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] exp_out(input int pos, input int gap,
                                         input logic valid, input logic [20:0] fr);
    int         slot, off;
    logic [6:0] s;
    logic       blank;
    slot = pos / (PRE + gap);
    off  = pos % (PRE + gap);
    if (!valid || off >= PRE) return ALL_OFF;
    s = (slot == 0) ? fr[20:14] : (slot == 1) ? fr[13:7] : fr[6:0];
    blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (slot == 0 && fr[20:14] == ZERO) blank = 1'b1;
    if (slot == 1 && fr[20:14] == ZERO && fr[13:7] == ZERO) blank = 1'b1;
`endif
    if (blank) return ALL_OFF;
    return {~(3'b100 >> slot), s};
  endfunction

  // Output in cycle n reflects scan position (n-1); display swaps at multiples of FRAME.
  always @(negedge clk) begin : monitor
    int         n;
    logic [9:0] e;
    if (rst_n === 1'b1) begin
      n = cyc;
      e = (n == 0) ? ALL_OFF : exp_out((n - 1) % FRAME, GAP, shown_valid, shown);
      check("dig_out", 32'(dig_out), 32'(e[9:7]));
      check("seg_out", 32'(seg_out), 32'(e[6:0]));
      check("frame_done", 32'(frame_done), 32'(n > 0 && n % FRAME == 0));
      if (n > 0 && n % FRAME == 0 && acc_q.size() > 0 && (acc_q[0] / FRAME + 1) * FRAME == n) begin
        shown       = exp_q.pop_front();
        void'(acc_q.pop_front());
        shown_valid = 1'b1;
      end
      check("in_ready", 32'(in_ready), 32'(acc_q.size() == 0));

      e = (n <= FRAME0) ? ALL_OFF : exp_out((n - 1) % FRAME0, 0, 1'b1, f0);
      check("nogap_dig_out", 32'(dig_out0), 32'(e[9:7]));
      check("nogap_seg_out", 32'(seg_out0), 32'(e[6:0]));
      check("nogap_frame_done", 32'(frame_done0), 32'(n > 0 && n % FRAME0 == 0));
    end
  end

  // driver tasks (all start and end at posedge + 1)
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
    seg_h    = h;
    seg_t    = t;
    seg_o    = o;
    in_valid = 1'b1;
    for (int k = 0; k < 4 * FRAME; k++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        exp_q.push_back({h, t, o});
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drained();
    for (int k = 0; k < 4 * FRAME && acc_q.size() > 0; k++) wait_cycles(1);
    check("drain_timeout", 32'(acc_q.size()), 32'd0);
  endtask

  task automatic wait_phase(input int ph);
    for (int k = 0; k < 2 * FRAME && (cyc % FRAME) != ph; k++) wait_cycles(1);
    check("phase_timeout", 32'(cyc % FRAME), 32'(ph));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    seg_h       = '0;
    seg_t       = '0;
    seg_o       = '0;
    shown       = '0;
    shown_valid = 1'b0;
    in_valid0   = 1'b1;
    f0          = {7'b1111111, 7'b1110000, 7'b1111011};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle: blank display, frame_done every FRAME cycles.
    wait_cycles(2 * FRAME + 4);

    // Digits 1, 2, 3.
    send_frame(7'b0110000, 7'b1101101, 7'b1111001);
    wait_cycles(2 * FRAME + 4);

    // Back-to-back frames: B waits for the boundary that shows A.
    send_frame(7'b1111001, 7'b0110011, 7'b1011011);
    send_frame(7'b1011111, 7'b1110000, 7'b1111111);
    wait_cycles(3 * FRAME);

    // Leading-zero patterns: 000, 051, 100.
    send_frame(ZERO, ZERO, ZERO);
    send_frame(ZERO, 7'b1011011, 7'b0110000);
    send_frame(7'b0110000, ZERO, ZERO);
    wait_cycles(2 * FRAME + 4);

    // Random patterns.
    repeat (4) send_frame(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                          7'($urandom_range(0, 127)));
    wait_drained();
    wait_cycles(FRAME + 2);

    // Reset during the tens slot with a frame pending.
    wait_phase(1);
    send_frame(7'b1111011, 7'b1111111, 7'b1110000);
    wait_phase(8);
    check("pending_before_reset", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_dig_out", 32'(dig_out), 32'h7);
    check("rst_seg_out", 32'(seg_out), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    acc_q.delete();
    shown_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(2 * FRAME + 4);

    send_frame(7'b1101101, ZERO, 7'b0110000);
    wait_drained();
    wait_cycles(FRAME + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
